// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: FSM state encodings,
// the NOP word held in IF/ID after reset, and the default datapath width.
// The default width follows the `FC_WIDTH macro when the build defines it.
`ifndef FC_WIDTH
`define FC_WIDTH 64
`endif

package fetch_ctrl_pkg;

  localparam int unsigned FC_XLEN = `FC_WIDTH;

  localparam logic [1:0] FC_BOOT = 2'd0;
  localparam logic [1:0] FC_RUN  = 2'd1;
  localparam logic [1:0] FC_HALT = 2'd2;

  localparam logic [31:0] FC_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating 64-bit event counter with enable, used by fetch_ctrl for its
// performance counters. Present only when FETCH_PERF_EN is defined.
// Ports: clk_i, rst_i (async, active-high), en_i (count this cycle),
//        cnt_o (current count, sticks at all-ones).
`ifdef FETCH_PERF_EN
module fetch_perf_ctr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  // Increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses instruction memory and
// registers the fetched word into IF/ID with a valid/ready handshake to decode.
// Waits in BOOT until boot_go, halts permanently on a misaligned redirect.
// Ports: sys_clk, sys_rst (async, active-high), boot_go, redirect_valid/pc,
//        imem_addr (combinational word address) / imem_rdata,
//        id_valid / id_ready, id_pc, id_pc_plus_4, id_instr, halted.
// Optional: FETCH_PERF_EN adds fetch_cnt and stall_cnt saturating counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       XLEN     = FC_XLEN,
  parameter int unsigned       IMEM_AW  = 8,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               boot_go,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_pc_plus_4,
  output logic [31:0]        id_instr,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]        fetch_cnt,
  output logic [63:0]        stall_cnt
`endif
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            halted_q, halted_d;
  logic            advance_c;
  logic            redir_bad_c;

  // IF/ID slot is free or being drained by decode this cycle.
  assign advance_c   = !id_valid_q || id_ready;
  assign redir_bad_c = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // State, PC and IF/ID registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= FC_BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_instr_q <= FC_NOP;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic; RUN priority: misaligned redirect, redirect, advance, hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_instr_d = id_instr_q;
    halted_d   = halted_q;
    case (state_q)
      FC_BOOT: begin
        id_valid_d = 1'b0;
        if (boot_go) state_d = FC_RUN;
      end
      FC_RUN: begin
        if (redir_bad_c) begin
          state_d    = FC_HALT;
          halted_d   = 1'b1;
          id_valid_d = 1'b0;
        end else if (redirect_valid) begin
          // Squash whatever IF/ID holds, even if decode is stalled.
          pc_d       = redirect_pc;
          id_valid_d = 1'b0;
        end else if (advance_c) begin
          id_pc_d    = pc_q;
          id_pc4_d   = pc_q + XLEN'(4);
          id_instr_d = imem_rdata;
          id_valid_d = 1'b1;
          pc_d       = pc_q + XLEN'(4);
        end
      end
      FC_HALT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d    = FC_HALT;
        halted_d   = 1'b1;
        id_valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr    = pc_q[IMEM_AW+1:2];
  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus_4 = id_pc4_q;
  assign id_instr     = id_instr_q;
  assign halted       = halted_q;

`ifdef FETCH_PERF_EN
  logic run_c, fetch_en_c, stall_en_c;

  assign run_c      = (state_q == FC_RUN);
  assign fetch_en_c = run_c && !redirect_valid && advance_c;
  assign stall_en_c = run_c && id_valid_q && !id_ready && !redirect_valid;

  fetch_perf_ctr u_fetch_ctr (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .en_i  (fetch_en_c),
    .cnt_o (fetch_cnt)
  );

  fetch_perf_ctr u_stall_ctr (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .en_i  (stall_en_c),
    .cnt_o (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the stimulus process queues the PCs it
// expects decode to accept; a negedge monitor pops and compares each accepted
// IF/ID transfer. Direct checks cover reset, stalls, redirects, halt and wrap.
module tb_fetch_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        boot_go;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus_4;
  logic [31:0] id_instr;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b1;
  logic [63:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  // Instruction memory model: word tagged with its own word address.
  assign imem_rdata = {16'hC0DE, 8'h00, imem_addr};

  fetch_ctrl dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .boot_go        (boot_go),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_pc_plus_4   (id_pc_plus_4),
    .id_instr       (id_instr),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    exp_instr = 32'hC0DE_0000 | {24'd0, pc[9:2]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // Monitor: every accepted transfer must match the head of the queue.
  always @(negedge sys_clk) begin
    if (mon_en && !sys_rst && id_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e);
        chk("sb_pc_plus_4", id_pc_plus_4, e + 64'd4);
        chk("sb_instr", 64'(id_instr), 64'(exp_instr(e)));
      end
    end
  end

  initial begin
    sys_rst        = 1'b1;
    boot_go        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    repeat (2) tick();
    sys_rst = 1'b0;

    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_pc4", id_pc_plus_4, 64'd0);
    chk("rst_instr", 64'(id_instr), 64'h13);

    repeat (5) tick();
    chk("boot_wait_valid", 64'(id_valid), 64'd0);
    chk("boot_wait_addr", 64'(imem_addr), 64'd0);

    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    exp_q.push_back(64'h40);
    exp_q.push_back(64'h3FC);
    exp_q.push_back(64'h400);

    boot_go = 1'b1;
    tick();
    chk("boot_edge1_valid", 64'(id_valid), 64'd0);
    tick();
    boot_go = 1'b0;
    chk("boot_edge2_valid", 64'(id_valid), 64'd1);
    chk("boot_edge2_pc", id_pc, 64'h0);
    tick();
    chk("seq_pc4", id_pc, 64'h4);
    tick();
    chk("seq_pc8", id_pc, 64'h8);
    id_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", id_pc, 64'h8);
      chk("stall_instr", 64'(id_instr), 64'(exp_instr(64'h8)));
      chk("stall_addr", 64'(imem_addr), 64'd3);
      chk("stall_valid", 64'(id_valid), 64'd1);
    end
    id_ready = 1'b1;
    tick();
    chk("release_pc", id_pc, 64'hC);

    // Redirect while decode stalls: pc 0xC is squashed.
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    tick();
    chk("redir_bubble_valid", 64'(id_valid), 64'd0);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    chk("redir_addr", 64'(imem_addr), 64'h10);
    tick();
    chk("redir_target_valid", 64'(id_valid), 64'd1);
    chk("redir_target_pc", id_pc, 64'h40);
    chk("redir_target_pc4", id_pc_plus_4, 64'h44);
    tick();
    chk("redir_next_pc", id_pc, 64'h44);

    // Misaligned redirect halts; further redirects and boot_go ignored.
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h42;
    tick();
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_valid", 64'(id_valid), 64'd0);
    redirect_pc = 64'h80;
    boot_go     = 1'b1;
    id_ready    = 1'b1;
    repeat (3) tick();
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("halt_sticky_valid", 64'(id_valid), 64'd0);
    chk("halt_pc_frozen", 64'(imem_addr), 64'h12);
    redirect_valid = 1'b0;
    boot_go        = 1'b0;

    sys_rst = 1'b1;
    #1;
    chk("halt_rst_flag", 64'(halted), 64'd0);
    chk("halt_rst_addr", 64'(imem_addr), 64'd0);
    tick();
    sys_rst = 1'b0;

    // Wrap of the 8-bit word address.
    boot_go = 1'b1;
    tick();
    boot_go        = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3FC;
    tick();
    chk("wrap_bubble_valid", 64'(id_valid), 64'd0);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick();
    chk("wrap_pc_3fc", id_pc, 64'h3FC);
    chk("wrap_addr_zero", 64'(imem_addr), 64'd0);
    tick();
    chk("wrap_pc_400", id_pc, 64'h400);
    chk("wrap_pc4_404", id_pc_plus_4, 64'h404);
    tick();
    chk("midrun_valid_pre", 64'(id_valid), 64'd1);
    sys_rst = 1'b1;
    #1;
    chk("midrun_rst_valid", 64'(id_valid), 64'd0);
    tick();
    sys_rst = 1'b0;

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

`ifdef FETCH_PERF_EN
    mon_en = 1'b0;
    chk("perf_fetch_rst", fetch_cnt, 64'd0);
    chk("perf_stall_rst", stall_cnt, 64'd0);
    boot_go = 1'b1;
    tick();
    boot_go  = 1'b0;
    id_ready = 1'b1;
    repeat (10) tick();
    id_ready = 1'b0;
    repeat (4) tick();
    chk("perf_fetch_cnt", fetch_cnt, 64'd10);
    chk("perf_stall_cnt", stall_cnt, 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
